wb_regfile: RTL

Write-back stage register file for the five-stage MIPS pipeline: it consumes the MEM/WB pipeline register outputs, selects the write-back value (memory load data or ALU result), and commits it into a 32-entry general-purpose register file. It also serves the decode stage's two combinational read ports. A same-cycle write-to-read bypass means decode never observes a stale value for a register being written back in that cycle. A retired-write counter supports debug and test.

---
 rtl/wb_regfile_if.sv | 46 ++++
 rtl/wb_regfile.sv | 58 +++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back controls and data, decode read ports,
// selected write-back value and the retired-write counter.
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ctrl_regWrite_mem_wb;
  logic                  ctrl_memToReg_mem_wb;
  logic [DATA_WIDTH-1:0] read_data_from_mem_mem_wb;
  logic [DATA_WIDTH-1:0] alu_result_mem_wb;
  logic [ADDR_WIDTH-1:0] write_register_mem_wb;
  logic [ADDR_WIDTH-1:0] read_register_1;
  logic [ADDR_WIDTH-1:0] read_register_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [DATA_WIDTH-1:0] write_data_wb;
  logic [31:0]           wb_commit_count;

  modport master (
    output ctrl_regWrite_mem_wb,
    output ctrl_memToReg_mem_wb,
    output read_data_from_mem_mem_wb,
    output alu_result_mem_wb,
    output write_register_mem_wb,
    output read_register_1,
    output read_register_2,
    input  read_data_1,
    input  read_data_2,
    input  write_data_wb,
    input  wb_commit_count
  );

  modport slave (
    input  ctrl_regWrite_mem_wb,
    input  ctrl_memToReg_mem_wb,
    input  read_data_from_mem_mem_wb,
    input  alu_result_mem_wb,
    input  write_register_mem_wb,
    input  read_register_1,
    input  read_register_2,
    output read_data_1,
    output read_data_2,
    output write_data_wb,
    output wb_commit_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it into
// 32 GPRs ($zero hardwired) and serves two bypassed combinational read ports.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [31:0]           commit_count;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  commit;
  logic                  bypass_1;
  logic                  bypass_2;
  logic [DATA_WIDTH-1:0] rd_1;
  logic [DATA_WIDTH-1:0] rd_2;

  assign wb_data = bus.ctrl_memToReg_mem_wb ? bus.read_data_from_mem_mem_wb
                                            : bus.alu_result_mem_wb;
  assign commit  = bus.ctrl_regWrite_mem_wb && (bus.write_register_mem_wb != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      commit_count <= '0;
    end else if (commit) begin
      regs[bus.write_register_mem_wb] <= wb_data;
      commit_count                    <= commit_count + 32'd1;
    end
  end

  // Bypass lets decode see the value being written back in this same cycle.
  assign bypass_1 = bus.ctrl_regWrite_mem_wb &&
                    (bus.write_register_mem_wb == bus.read_register_1);
  assign bypass_2 = bus.ctrl_regWrite_mem_wb &&
                    (bus.write_register_mem_wb == bus.read_register_2);

  always_comb begin
    rd_1 = regs[bus.read_register_1];
    if (!reset || (bus.read_register_1 == '0)) rd_1 = '0;
    else if (bypass_1)                         rd_1 = wb_data;
  end

  always_comb begin
    rd_2 = regs[bus.read_register_2];
    if (!reset || (bus.read_register_2 == '0)) rd_2 = '0;
    else if (bypass_2)                         rd_2 = wb_data;
  end

  assign bus.read_data_1     = rd_1;
  assign bus.read_data_2     = rd_2;
  assign bus.write_data_wb   = wb_data;
  assign bus.wb_commit_count = commit_count;
endmodule
